// File: rtl/dffram_banked.sv
// dffram_banked: BANKS byte-writable DFF RAM banks behind one request port.
// Reads return through a registered bank select and a 2-entry response FIFO.
module dffram_bank #(
    parameter int AW   = 10,
    parameter int COLS = 4
) (
    input  logic                CLK,
    input  logic                EN,
    input  logic [COLS-1:0]     WE,
    input  logic [AW-1:0]       A,
    input  logic [8*COLS-1:0]   Di,
    output logic [8*COLS-1:0]   Do
);
    logic [8*COLS-1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (EN) begin
            for (int i = 0; i < COLS; i++)
                if (WE[i]) mem[A][8*i +: 8] <= Di[8*i +: 8];
            Do <= mem[A];
        end
    end
endmodule

module dffram_banked #(
    parameter int BANKS   = 8,
    parameter int BANK_AW = 10,
    parameter int COLS    = 4,
    localparam int BW     = $clog2(BANKS),
    localparam int AW     = BW + BANK_AW,
    localparam int DW     = 8 * COLS
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [COLS-1:0] WE,
    input  logic [AW-1:0]   A,
    input  logic [DW-1:0]   Di,
    output logic [DW-1:0]   Do,
    output logic            DO_VALID,
    input  logic            DO_READY
);
    logic [BANKS-1:0] en;
    logic [DW-1:0]    bank_do [BANKS];
    logic [DW-1:0]    fifo [2];
    logic [BW-1:0]    bank;
    logic [BW-1:0]    sel_q;
    logic [1:0]       count;
    logic             inflight;
    logic             accept;
    logic             rd;
    logic             pop;
    logic             wr_ptr;
    logic             rd_ptr;

    assign bank      = A[AW-1:BANK_AW];
    assign DO_VALID  = count != 2'd0;
    assign pop       = DO_VALID & DO_READY;
    // An in-flight read already owns a FIFO slot, so it counts toward occupancy.
    assign REQ_READY = ((count + {1'b0, inflight}) < 2'd2) | pop;
    assign accept    = REQ_VALID & REQ_READY;
    assign rd        = accept & ~|WE;
    assign Do        = DO_VALID ? fifo[rd_ptr] : '0;

    genvar g;
    generate
        for (g = 0; g < BANKS; g++) begin : g_bank
            assign en[g] = accept & (bank == BW'(g));
            dffram_bank #(.AW(BANK_AW), .COLS(COLS)) u_bank (
                .CLK (CLK),
                .EN  (en[g]),
                .WE  (WE),
                .A   (A[BANK_AW-1:0]),
                .Di  (Di),
                .Do  (bank_do[g])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inflight <= 1'b0;
            sel_q    <= '0;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            inflight <= rd;
            if (rd) sel_q <= bank;
            if (inflight) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // Storage needs no reset: Do is forced to zero while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (inflight) fifo[wr_ptr] <= bank_do[sel_q];
    end
endmodule

// File: tb/tb_dffram_banked.sv
// tb_dffram_banked: directed requests with a response scoreboard checked by a monitor.
module tb_dffram_banked;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [3:0]  WE;
    logic [12:0] A;
    logic [31:0] Di;
    logic [31:0] Do;
    logic        DO_VALID;
    logic        DO_READY;

    typedef struct { logic [31:0] d; int c; } exp_t;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   a1, a2, a3;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_do;

    dffram_banked dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .WE        (WE),
        .A         (A),
        .Di        (Di),
        .Do        (Do),
        .DO_VALID  (DO_VALID),
        .DO_READY  (DO_READY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response popped must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (!DO_VALID) chk("do_zero", Do, 32'h0);
            if (DO_VALID && sb.size() == 0) chk("unexpected_resp", {31'b0, DO_VALID}, 32'h0);
            if (prev_hold) begin
                chk("hold_valid", {31'b0, DO_VALID}, 32'h1);
                chk("hold_data", Do, prev_do);
            end
            if (DO_VALID && DO_READY && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", Do, e.d);
                if (e.c >= 0) chk("rd_latency", cyc, e.c);
            end
            prev_hold = DO_VALID && !DO_READY;
            prev_do   = Do;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic req(input logic [3:0] we, input logic [12:0] a, input logic [31:0] di,
                       input logic [31:0] exp, input bit lat, output int acc);
        int n = 0;
        REQ_VALID = 1'b1; WE = we; A = a; Di = di;
        @(negedge CLK);
        while (!REQ_READY && n < 50) begin
            n++;
            @(negedge CLK);
        end
        chk("req_ready", {31'b0, REQ_READY}, 32'h1);
        chk("bank_en", {24'b0, dut.en}, 32'(1) << a[12:10]);
        acc = cyc;
        if (we == 4'b0) sb.push_back('{exp, lat ? cyc + 2 : -1});
        @(posedge CLK); #1;
        REQ_VALID = 1'b0; WE = 4'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N = 1'b0; REQ_VALID = 1'b0; WE = 4'b0; A = '0; Di = '0; DO_READY = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_do_valid", {31'b0, DO_VALID}, 32'h0);
        chk("rst_do", Do, 32'h0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_req_ready", {31'b0, REQ_READY}, 32'h1);
        chk("idle_en", {24'b0, dut.en}, 32'h0);
        @(posedge CLK); #1;

        // Full-word write then read of bank 0
        req(4'b1111, 13'h0005, 32'hDEADBEEF, '0, 1'b0, a1);
        req(4'b0000, 13'h0005, '0, 32'hDEADBEEF, 1'b1, a1);
        idle(4);

        // Partial byte write in bank 7
        req(4'b1111, 13'h1C05, 32'hFFFFFFFF, '0, 1'b0, a1);
        req(4'b0011, 13'h1C05, 32'h12345678, '0, 1'b0, a1);
        req(4'b0000, 13'h1C05, '0, 32'hFFFF5678, 1'b1, a1);
        idle(4);

        // Back-to-back reads across banks, one accepted per cycle
        req(4'b0000, 13'h0005, '0, 32'hDEADBEEF, 1'b1, a1);
        req(4'b0000, 13'h1C05, '0, 32'hFFFF5678, 1'b1, a2);
        req(4'b0000, 13'h0005, '0, 32'hDEADBEEF, 1'b1, a3);
        chk("b2b_accept_1", a2 - a1, 32'h1);
        chk("b2b_accept_2", a3 - a2, 32'h1);
        idle(4);

        // Backpressure: two reads fill the FIFO, a third must stall
        DO_READY = 1'b0;
        req(4'b0000, 13'h0005, '0, 32'hDEADBEEF, 1'b0, a1);
        req(4'b0000, 13'h1C05, '0, 32'hFFFF5678, 1'b0, a2);
        REQ_VALID = 1'b1; A = 13'h0005;
        repeat (3) begin
            @(negedge CLK);
            chk("bp_req_ready", {31'b0, REQ_READY}, 32'h0);
            chk("bp_do_valid", {31'b0, DO_VALID}, 32'h1);
            chk("bp_do", Do, 32'hDEADBEEF);
        end
        REQ_VALID = 1'b0;
        @(posedge CLK); #1;
        DO_READY = 1'b1;
        idle(4);
        @(negedge CLK);
        chk("bp_ready_back", {31'b0, REQ_READY}, 32'h1);
        chk("bp_drained", sb.size(), 32'h0);
        @(posedge CLK); #1;

        // Read-after-write on consecutive cycles
        req(4'b1111, 13'h0400, 32'hAABBCCDD, '0, 1'b0, a1);
        req(4'b0000, 13'h0400, '0, 32'hAABBCCDD, 1'b1, a2);
        chk("raw_accept", a2 - a1, 32'h1);
        idle(4);

        // Reset with one read queued and one in flight
        DO_READY = 1'b0;
        req(4'b0000, 13'h0005, '0, 32'hDEADBEEF, 1'b0, a1);
        req(4'b0000, 13'h1C05, '0, 32'hFFFF5678, 1'b0, a2);
        RST_N = 1'b0;
        #1;
        chk("arst_do_valid", {31'b0, DO_VALID}, 32'h0);
        chk("arst_do", Do, 32'h0);
        sb.delete();
        DO_READY = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        chk("arst_req_ready", {31'b0, REQ_READY}, 32'h1);
        @(posedge CLK); #1;
        req(4'b0000, 13'h0005, '0, 32'hDEADBEEF, 1'b1, a1);
        req(4'b0000, 13'h1C05, '0, 32'hFFFF5678, 1'b1, a2);
        req(4'b0000, 13'h0400, '0, 32'hAABBCCDD, 1'b1, a3);
        idle(6);
        chk("final_drained", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
